// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-side blocks: the arbiter state
// encoding, default parameter values and the starve-counter helper.
package cpu_pkg;

  // Default number of consecutive data grants allowed while fetch waits.
  localparam int STARVE_LIMIT_DEF = 4;

  // Default address/data width.
  localparam int AW_DEF = 32;

  // Width of the starve counter; large enough for any practical limit.
  localparam int CNT_W = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arbState_t;

  // Saturating increment: counts up by one but never past lim.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v,
                                              input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] res;
    if (v >= lim) begin
      res = lim;
    end else begin
      res = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share a
// single memory. Data normally wins, but after STARVE_LIMIT consecutive data
// grants with fetch waiting, fetch is granted once. Every access walks
// IDLE -> BUSY_x -> RESP, and the ready pulse of the served port coincides
// with RESP.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [AW-1:0] if_rdata,
  output logic          if_ready,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] d_wdata,
  output logic [AW-1:0] d_rdata,
  output logic          d_ready,
  // shared memory
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata,
  input  logic          mem_ack,
  // pipeline stalls
  output logic          stall_F,
  output logic          stall_M
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arbState_t        stateR;
  logic [CNT_W-1:0] starveCntR;

  logic             grantDataS;
  logic             grantFetchS;
  logic [CNT_W-1:0] nextCntS;

  // Grant decision and next starve-count value, only used while in IDLE.
  always_comb begin
    grantDataS  = 1'b0;
    grantFetchS = 1'b0;
    nextCntS    = {CNT_W{1'b0}};
    if (d_req && (starveCntR < LIMIT_C)) begin
      grantDataS = 1'b1;
      if (if_req) begin
        nextCntS = satInc(starveCntR, LIMIT_C);
      end else begin
        nextCntS = {CNT_W{1'b0}};
      end
    end else if (if_req) begin
      grantFetchS = 1'b1;
      nextCntS    = {CNT_W{1'b0}};
    end else if (d_req) begin
      // fetch is not waiting here, so the starvation history is dropped
      grantDataS = 1'b1;
      nextCntS   = {CNT_W{1'b0}};
    end else begin
      nextCntS = {CNT_W{1'b0}};
    end
  end

  // Arbiter FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR     <= IDLE;
      starveCntR <= {CNT_W{1'b0}};
      if_rdata   <= {AW{1'b0}};
      d_rdata    <= {AW{1'b0}};
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {AW{1'b0}};
      mem_wdata  <= {AW{1'b0}};
    end else begin
      // ready strobes are single-cycle unless raised below
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (stateR)
        IDLE: begin
          starveCntR <= nextCntS;
          if (grantDataS) begin
            stateR    <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grantFetchS) begin
            stateR    <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= {AW{1'b0}};
          end else begin
            stateR    <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {AW{1'b0}};
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            stateR    <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {AW{1'b0}};
            if_rdata  <= mem_rdata;
            if_ready  <= 1'b1;
          end else begin
            stateR <= BUSY_I;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            stateR    <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {AW{1'b0}};
            d_rdata   <= mem_rdata;
            d_ready   <= 1'b1;
          end else begin
            stateR <= BUSY_D;
          end
        end
        RESP: begin
          // requests still high here belong to the access just finished
          stateR <= IDLE;
        end
        default: begin
          stateR    <= IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= {AW{1'b0}};
          mem_wdata <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Stalls follow the request/ready handshake combinationally.
  assign stall_F = if_req & ~if_ready;
  assign stall_M = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard: expected grants and
// expected ready responses are queued by the stimulus and checked by a
// monitor that watches the memory side and the ready strobes.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_F;
  logic        stall_M;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        isData;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
  } grant_t;

  resp_t  respQ[$];
  grant_t grantQ[$];

  // memory responder controls
  int          latency     = 0;
  logic        forceAck    = 1'b0;
  logic        useAddrData = 1'b0;
  logic [31:0] respData    = 32'h0;
  int          waitCnt     = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_F  (stall_F),
    .stall_M  (stall_M)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic expectGrant(input logic [31:0] a, input logic we);
    grant_t g;
    g.addr = a;
    g.we   = we;
    grantQ.push_back(g);
  endtask

  task automatic expectResp(input logic isData, input logic [31:0] data);
    resp_t r;
    r.isData = isData;
    r.data   = data;
    respQ.push_back(r);
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_mem_req"}, mem_req, 1'b0);
    checkBit({tag, "_mem_we"}, mem_we, 1'b0);
    check32({tag, "_mem_addr"}, mem_addr, 32'h0);
    check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check32({tag, "_if_rdata"}, if_rdata, 32'h0);
    check32({tag, "_d_rdata"}, d_rdata, 32'h0);
    checkBit({tag, "_if_ready"}, if_ready, 1'b0);
    checkBit({tag, "_d_ready"}, d_ready, 1'b0);
  endtask

  // Memory model: acks after 'latency' wait cycles, or constantly when forced.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (forceAck) begin
        mem_ack   = 1'b1;
        mem_rdata = respData;
      end else if (mem_req) begin
        if (waitCnt >= latency) begin
          mem_ack   = 1'b1;
          mem_rdata = useAddrData ? (mem_addr + 32'h1000_0000) : respData;
        end else begin
          mem_ack = 1'b0;
          waitCnt++;
        end
      end else begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end
    end
  end

  // Monitor: scoreboards every ready pulse and every new memory grant.
  initial begin
    resp_t  e;
    grant_t g;
    logic   memReqPrev;
    memReqPrev = 1'b0;
    forever begin
      @(negedge clk);
      if (if_ready || d_ready) begin
        checks++;
        if (if_ready && d_ready) begin
          errors++;
          $display("FAIL resp_both: if_ready=1 d_ready=1 expected one");
        end else if (respQ.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: if_ready=%b d_ready=%b expected none", if_ready, d_ready);
        end else begin
          e = respQ.pop_front();
          if (e.isData !== d_ready || (d_ready ? d_rdata : if_rdata) !== e.data) begin
            errors++;
            $display("FAIL resp_data: got port_d=%b data=%h expected port_d=%b data=%h",
                     d_ready, d_ready ? d_rdata : if_rdata, e.isData, e.data);
          end
        end
      end
      if (mem_req && !memReqPrev) begin
        checks++;
        if (grantQ.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got addr=%h expected none", mem_addr);
        end else begin
          g = grantQ.pop_front();
          if (mem_addr !== g.addr || mem_we !== g.we) begin
            errors++;
            $display("FAIL grant: got addr=%h we=%b expected addr=%h we=%b",
                     mem_addr, mem_we, g.addr, g.we);
          end
        end
      end
      memReqPrev = mem_req;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int   reqCycles;
    logic seen;
    logic gotF;
    logic gotD;
    int   pulses;
    int   busyCycles;

    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b1;
    tick();

    // Single fetch, zero-wait memory
    latency  = 0;
    respData = 32'hDEADBEEF;
    expectGrant(32'h10, 1'b0);
    expectResp(1'b0, 32'hDEADBEEF);
    if_addr = 32'h10;
    if_req  = 1'b1;
    tick();
    checkBit("f_busy_mem_req", mem_req, 1'b1);
    check32("f_busy_mem_addr", mem_addr, 32'h10);
    checkBit("f_busy_mem_we", mem_we, 1'b0);
    checkBit("f_busy_stall_F", stall_F, 1'b1);
    tick();
    checkBit("f_resp_if_ready", if_ready, 1'b1);
    check32("f_resp_if_rdata", if_rdata, 32'hDEADBEEF);
    checkBit("f_resp_mem_req", mem_req, 1'b0);
    check32("f_resp_mem_addr", mem_addr, 32'h0);
    if_req = 1'b0;
    tick();
    checkBit("f_idle_if_ready", if_ready, 1'b0);

    // Data write with two wait cycles
    latency  = 2;
    respData = 32'hCAFE0001;
    expectGrant(32'h40, 1'b1);
    expectResp(1'b1, 32'hCAFE0001);
    d_addr  = 32'h40;
    d_wdata = 32'h55;
    d_we    = 1'b1;
    d_req   = 1'b1;
    reqCycles = 0;
    seen      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!seen) begin
        tick();
        if (mem_req && mem_we && mem_addr == 32'h40 && mem_wdata == 32'h55) reqCycles++;
        if (d_ready) seen = 1'b1;
      end
    end
    checkBit("w_ready_seen", seen, 1'b1);
    check32("w_req_cycles", 32'(reqCycles), 32'd3);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    checkBit("w_stall_M_after", stall_M, 1'b0);
    checkBit("w_d_ready_after", d_ready, 1'b0);
    check32("w_if_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Both ports requesting from reset release: starvation relief
    reset       = 1'b0;
    latency     = 1;
    useAddrData = 1'b1;
    if_addr     = 32'h100;
    if_req      = 1'b1;
    d_addr      = 32'h200;
    d_we        = 1'b0;
    d_req       = 1'b1;
    expectGrant(32'h200, 1'b0);
    expectGrant(32'h204, 1'b0);
    expectGrant(32'h208, 1'b0);
    expectGrant(32'h20C, 1'b0);
    expectGrant(32'h100, 1'b0);
    expectGrant(32'h210, 1'b0);
    expectResp(1'b1, 32'h1000_0200);
    expectResp(1'b1, 32'h1000_0204);
    expectResp(1'b1, 32'h1000_0208);
    expectResp(1'b1, 32'h1000_020C);
    expectResp(1'b0, 32'h1000_0100);
    expectResp(1'b1, 32'h1000_0210);
    tick();
    reset = 1'b1;
    fork
      begin
        tick();
        checkBit("s_stall_F_data_first", stall_F, 1'b1);
        gotF = 1'b0;
        for (int k = 0; k < 200; k++) begin
          if (!gotF) begin
            tick();
            if (if_ready) gotF = 1'b1;
          end
        end
        if_req = 1'b0;
        checkBit("s_fetch_done", gotF, 1'b1);
      end
      begin
        for (int n = 0; n < 5; n++) begin
          gotD = 1'b0;
          for (int k = 0; k < 200; k++) begin
            if (!gotD) begin
              tick();
              if (d_ready) gotD = 1'b1;
            end
          end
          checkBit("s_data_done", gotD, 1'b1);
          if (n < 4) begin
            d_addr = d_addr + 32'h4;
          end else begin
            d_req = 1'b0;
          end
        end
      end
    join
    tick();

    // Reset in the middle of a data read
    useAddrData = 1'b0;
    respData    = 32'h77777777;
    latency     = 5;
    expectGrant(32'h300, 1'b0);
    d_addr = 32'h300;
    d_we   = 1'b0;
    d_req  = 1'b1;
    tick();
    tick();
    checkBit("r_busy_mem_req", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkAllZero("r_async");
    tick();
    tick();
    reset  = 1'b1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (d_ready) pulses++;
    end
    check32("r_no_ready_after", 32'(pulses), 32'd0);
    checkBit("r_mem_req_idle", mem_req, 1'b0);

    // Stray ack while idle
    respData  = 32'h12345678;
    forceAck  = 1'b1;
    pulses    = 0;
    busyCycles = 0;
    repeat (4) begin
      tick();
      if (if_ready || d_ready) pulses++;
      if (mem_req) busyCycles++;
    end
    check32("a_no_ready", 32'(pulses), 32'd0);
    check32("a_no_mem_req", 32'(busyCycles), 32'd0);
    forceAck = 1'b0;
    tick();

    // Fetch request held through its own response
    latency  = 1;
    respData = 32'h0BADF00D;
    expectGrant(32'h20, 1'b0);
    expectResp(1'b0, 32'h0BADF00D);
    if_addr = 32'h20;
    if_req  = 1'b1;
    tick();
    checkBit("h_granted_from_idle", mem_req, 1'b1);
    pulses = 0;
    seen   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!seen) begin
        tick();
        if (if_ready) begin
          seen = 1'b1;
          pulses++;
        end
      end
    end
    checkBit("h_ready_seen", seen, 1'b1);
    tick();
    checkBit("h_no_regrant", mem_req, 1'b0);
    if (if_ready) pulses++;
    if_req     = 1'b0;
    busyCycles = 0;
    repeat (5) begin
      tick();
      if (if_ready) pulses++;
      if (mem_req) busyCycles++;
    end
    check32("h_one_pulse", 32'(pulses), 32'd1);
    check32("h_no_later_grant", 32'(busyCycles), 32'd0);

    repeat (3) tick();
    check32("grant_queue_empty", 32'(grantQ.size()), 32'd0);
    check32("resp_queue_empty", 32'(respQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
